// File: rtl/bmp_pkg.sv
// Shared screen geometry, reader state encoding and intensity helper for the
// BMP placer and the region reader.
package bmp_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam logic [8:0] TRANSPARENT = 9'h088;

  typedef enum logic [2:0] {RD_IDLE, RD_SCAN, RD_DRAIN, RD_EMIT, RD_DONE} rd_state_t;

  // Clamp a scaled ink count into an 8-bit grayscale value.
  function automatic logic [7:0] sat255(input logic [15:0] v);
    return (v > 16'd255) ? 8'hFF : v[7:0];
  endfunction
endpackage

// File: rtl/bmp_block_accum.sv
// Bank of per-block-column ink counters; a clear on the same index as an
// increment takes priority.
module bmp_block_accum
  import bmp_pkg::*;
#(
  parameter int N  = 28,
  parameter int CW = 7,
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_en,
  input  logic [IW-1:0] inc_idx,
  input  logic          clr_en,
  input  logic [IW-1:0] clr_idx,
  input  logic [IW-1:0] rd_idx,
  output logic [CW-1:0] rd_cnt
);
  logic [CW-1:0] cnt [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (clr_en && clr_idx == IW'(i))
          cnt[i] <= '0;
        else if (inc_en && inc_idx == IW'(i))
          cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  assign rd_cnt = cnt[rd_idx];
endmodule

// File: rtl/bmp_region_reader.sv
// Reads a W x W screen region from videoMem, counts ink per SCALE x SCALE block
// and writes an IMG_DIM x IMG_DIM grayscale image, one block row at a time.
module bmp_region_reader
  import bmp_pkg::*;
#(
  parameter int         IMG_DIM  = 28,
  parameter int         SCALE    = 8,
  parameter logic [8:0] BG_COLOR = 9'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  xloc,
  input  logic [8:0]  yloc,
  output logic [18:0] raddr,
  input  logic [8:0]  rdata,
  output logic        obuf_we,
  output logic [9:0]  obuf_addr,
  output logic [7:0]  obuf_data,
  output logic        busy,
  output logic        done
);
  localparam int W        = IMG_DIM * SCALE;
  localparam int LG_SCALE = $clog2(SCALE);
  localparam int CNT_W    = $clog2(SCALE * SCALE + 1);
  localparam int COL_W    = (W > 1) ? $clog2(W) : 1;
  localparam int ROW_W    = (SCALE > 1) ? LG_SCALE : 1;
  localparam int BLK_W    = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;
  localparam int GAIN_SH  = 8 - 2 * LG_SCALE;

  rd_state_t        state_reg, state_next;
  logic [9:0]       x0_reg;
  logic [9:0]       line_y_reg, line_y_next;
  logic [18:0]      line_base_reg, line_base_next;
  logic [18:0]      raddr_reg, raddr_next, start_base;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg;
  logic [BLK_W-1:0] blk_row_reg, j_reg, blk_d_reg;
  logic             vld_d_reg;
  logic [10:0]      x_cur, x_next;
  logic             in_bounds, next_in_bounds;
  logic             last_col, last_row, last_j, last_blk_row;
  logic [CNT_W-1:0] rd_cnt;

  assign last_col     = col_reg == COL_W'(W - 1);
  assign last_row     = row_reg == ROW_W'(SCALE - 1);
  assign last_j       = j_reg == BLK_W'(IMG_DIM - 1);
  assign last_blk_row = blk_row_reg == BLK_W'(IMG_DIM - 1);
  assign start_base   = 19'(yloc) * 19'(SCREEN_W) + 19'(xloc);

  assign x_cur     = 11'(x0_reg) + 11'(col_reg);
  assign in_bounds = (x_cur < 11'(SCREEN_W)) && (line_y_reg < 10'(SCREEN_H));

  // line_base tracks the address of region column 0 on the current line; off-screen
  // pixels leave raddr parked on the last legal address.
  always_comb begin
    col_next       = last_col ? '0 : col_reg + COL_W'(1);
    line_y_next    = last_col ? line_y_reg + 10'd1 : line_y_reg;
    line_base_next = last_col ? line_base_reg + 19'(SCREEN_W) : line_base_reg;
    x_next         = 11'(x0_reg) + 11'(col_next);
    next_in_bounds = (x_next < 11'(SCREEN_W)) && (line_y_next < 10'(SCREEN_H));
    raddr_next     = next_in_bounds ? line_base_next + 19'(col_next) : raddr_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= RD_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    obuf_we    = 1'b0;
    obuf_addr  = '0;
    obuf_data  = '0;
    case (state_reg)
      RD_IDLE:  if (start) state_next = RD_SCAN;
      RD_SCAN: begin
        busy = 1'b1;
        if (last_col && last_row) state_next = RD_DRAIN;
      end
      RD_DRAIN: begin
        busy       = 1'b1;
        state_next = RD_EMIT;
      end
      RD_EMIT: begin
        busy      = 1'b1;
        obuf_we   = 1'b1;
        obuf_addr = 10'(blk_row_reg * IMG_DIM) + 10'(j_reg);
        obuf_data = sat255(16'(rd_cnt) << GAIN_SH);
        if (last_j) state_next = last_blk_row ? RD_DONE : RD_SCAN;
      end
      RD_DONE: begin
        done       = 1'b1;
        state_next = RD_IDLE;
      end
      default: state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_reg        <= '0;
      line_y_reg    <= '0;
      line_base_reg <= '0;
      raddr_reg     <= '0;
      col_reg       <= '0;
      row_reg       <= '0;
      blk_row_reg   <= '0;
      j_reg         <= '0;
      vld_d_reg     <= 1'b0;
      blk_d_reg     <= '0;
    end else begin
      // Tag travels alongside the synchronous RAM read latency.
      vld_d_reg <= (state_reg == RD_SCAN) && in_bounds;
      blk_d_reg <= BLK_W'(col_reg >> LG_SCALE);
      case (state_reg)
        RD_IDLE: if (start) begin
          x0_reg        <= xloc;
          line_y_reg    <= 10'(yloc);
          line_base_reg <= start_base;
          if (xloc < 10'(SCREEN_W) && yloc < 9'(SCREEN_H)) raddr_reg <= start_base;
          col_reg       <= '0;
          row_reg       <= '0;
          blk_row_reg   <= '0;
          j_reg         <= '0;
        end
        RD_SCAN: begin
          col_reg       <= col_next;
          line_y_reg    <= line_y_next;
          line_base_reg <= line_base_next;
          raddr_reg     <= raddr_next;
          if (last_col) row_reg <= last_row ? '0 : row_reg + ROW_W'(1);
        end
        RD_EMIT: begin
          j_reg <= last_j ? '0 : j_reg + BLK_W'(1);
          if (last_j) blk_row_reg <= blk_row_reg + BLK_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign raddr = raddr_reg;

  bmp_block_accum #(.N(IMG_DIM), .CW(CNT_W), .IW(BLK_W)) u_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_en  (vld_d_reg && (rdata != BG_COLOR)),
    .inc_idx (blk_d_reg),
    .clr_en  (state_reg == RD_EMIT),
    .clr_idx (j_reg),
    .rd_idx  (j_reg),
    .rd_cnt  (rd_cnt)
  );
endmodule

// File: tb/tb_bmp_region_reader.sv
// Randomized bench for bmp_region_reader: a screen-memory model feeds the DUT and a
// block-counting reference predicts every image write.
module tb_bmp_region_reader;
  localparam int IMG   = 4;
  localparam int S     = 8;
  localparam int W     = IMG * S;
  localparam int NPIX  = IMG * IMG;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int LAT   = IMG * (S * W + 1 + IMG) + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  xloc = '0;
  logic [8:0]  yloc = '0;
  logic [18:0] raddr;
  logic [8:0]  rdata = '0;
  logic        obuf_we;
  logic [9:0]  obuf_addr;
  logic [7:0]  obuf_data;
  logic        busy, done;

  bmp_region_reader #(.IMG_DIM(IMG), .SCALE(S), .BG_COLOR(9'h000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .xloc(xloc), .yloc(yloc),
    .raddr(raddr), .rdata(rdata), .obuf_we(obuf_we), .obuf_addr(obuf_addr),
    .obuf_data(obuf_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [8:0] mem [SCR_W * SCR_H];
  always @(posedge clk) rdata <= (int'(raddr) < SCR_W * SCR_H) ? mem[raddr] : 9'h000;

  typedef struct {int addr; int data;} wr_t;
  wr_t exp_q[$];
  int  checks = 0, failures = 0;
  int  cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0;
  int  n_writes = 0, collide = 0, clip_viol = 0, clip_min = 0;
  bit  clip_mon = 1'b0;
  int  out_img [NPIX];
  int  raddr_at [2*W+1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Compare process: every image write against the model queue, plus done/busy sanity.
  always @(negedge clk) begin : mon
    int  d;
    wr_t e;
    if (rst_n) begin
      d = cyc - start_cyc - 1;
      if (d >= 0 && d <= 2*W) raddr_at[d] = int'(raddr);
      if (obuf_we) begin
        checks++;
        n_writes++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_write actual addr=%0d data=%0d required none", obuf_addr, obuf_data);
        end else begin
          e = exp_q.pop_front();
          if (int'(obuf_addr) != e.addr || int'(obuf_data) != e.data) begin
            failures++;
            $display("FAIL obuf_write actual addr=%0d data=%0d required addr=%0d data=%0d",
                     obuf_addr, obuf_data, e.addr, e.data);
          end
        end
        if (int'(obuf_addr) < NPIX) out_img[obuf_addr] = int'(obuf_data);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        checks++;
        if (busy) begin
          failures++;
          $display("FAIL busy_at_done actual=1 required=0");
        end
      end
      if (clip_mon && busy && (int'(raddr) % SCR_W) < clip_min) clip_viol++;
      if (dut.u_accum.inc_en && dut.u_accum.clr_en && dut.u_accum.inc_idx == dut.u_accum.clr_idx)
        collide++;
    end
  end

  function automatic int model_block(input int x0, input int y0, input int bi, input int bj);
    int n, v, x, y;
    n = 0;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin
        x = x0 + bj * S + c;
        y = y0 + bi * S + r;
        if (x < SCR_W && y < SCR_H && mem[y * SCR_W + x] != 9'h000) n++;
      end
    v = n * 256 / (S * S);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic build_model(input int x0, input int y0);
    wr_t e;
    exp_q.delete();
    for (int bi = 0; bi < IMG; bi++)
      for (int bj = 0; bj < IMG; bj++) begin
        e.addr = bi * IMG + bj;
        e.data = model_block(x0, y0, bi, bj);
        exp_q.push_back(e);
      end
  endtask

  task automatic fill(input logic [8:0] v);
    for (int i = 0; i < SCR_W * SCR_H; i++) mem[i] = v;
  endtask

  task automatic fill_rand(input int dens);
    for (int i = 0; i < SCR_W * SCR_H; i++)
      mem[i] = (int'($urandom_range(99)) < dens) ? 9'($urandom_range(511, 1)) : 9'h000;
  endtask

  task automatic run_img(input string name, input int x0, input int y0, input int restart_at);
    int k;
    build_model(x0, y0);
    for (int i = 0; i < NPIX; i++) out_img[i] = -1;
    done_cnt = 0;
    n_writes = 0;
    @(negedge clk);
    xloc = 10'(x0); yloc = 9'(y0); start = 1'b1; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy_after_start"}, int'(busy), 1);
    k = 0;
    while (done_cnt == 0 && k < LAT + 100) begin
      @(negedge clk);
      start = (restart_at > 0 && k == restart_at);
      if (start) begin xloc = 10'($urandom); yloc = 9'($urandom); end
      k++;
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk({name, "_done_count"}, done_cnt, 1);
    chk({name, "_latency"}, done_cyc - start_cyc + 1, LAT);
    chk({name, "_missing_writes"}, exp_q.size(), 0);
    $display("run %s xloc=%0d yloc=%0d writes=%0d", name, x0, y0, n_writes);
  endtask

  function automatic int count_not(input int v, input int skip_addr);
    int bad;
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (i != skip_addr && out_img[i] != v) bad++;
    return bad;
  endfunction

  initial begin
    fill(9'h000);
    repeat (2) @(negedge clk);
    chk("rst_raddr", int'(raddr), 0);
    chk("rst_obuf_we", int'(obuf_we), 0);
    chk("rst_obuf_addr", int'(obuf_addr), 0);
    chk("rst_obuf_data", int'(obuf_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All background
    run_img("all_bg", 0, 0, 0);
    chk("all_bg_image", count_not(0, -1), 0);

    // All ink, address start and first line wrap
    fill(9'h1FF);
    chk("model_pin_full", model_block(100, 50, 0, 0), 255);
    run_img("all_ink", 100, 50, 0);
    chk("all_ink_image", count_not(255, -1), 0);
    chk("first_raddr", raddr_at[0], 32100);
    chk("wrap_raddr", raddr_at[W], 32740);

    // One full block of transparent-key ink at block (3,1)
    fill(9'h000);
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) mem[(50 + 3*S + r) * SCR_W + 100 + S + c] = 9'h088;
    chk("model_pin_square", model_block(100, 50, 3, 1), 255);
    run_img("square", 100, 50, 0);
    chk("square_hit", out_img[3*IMG + 1], 255);
    chk("square_rest", count_not(0, 3*IMG + 1), 0);

    // One ink pixel per block -> 4 each
    fill(9'h000);
    for (int bi = 0; bi < IMG; bi++)
      for (int bj = 0; bj < IMG; bj++)
        mem[(20 + bi*S + int'($urandom_range(S-1))) * SCR_W + 40 + bj*S + int'($urandom_range(S-1))] = 9'h0C3;
    chk("model_pin_single", model_block(40, 20, 2, 2), 4);
    run_img("one_per_block", 40, 20, 0);
    chk("one_per_block_image", count_not(4, -1), 0);

    // Half-filled block (1,2) -> 128
    fill(9'h000);
    for (int r = 0; r < S/2; r++)
      for (int c = 0; c < S; c++) mem[(20 + S + r) * SCR_W + 40 + 2*S + c] = 9'h001;
    run_img("half_block", 40, 20, 0);
    chk("half_block_hit", out_img[1*IMG + 2], 128);
    chk("half_block_rest", count_not(0, 1*IMG + 2), 0);

    // Right-edge and bottom-edge clipping
    fill_rand(50);
    clip_viol = 0; clip_min = 620; clip_mon = 1'b1;
    run_img("clip_x", 620, 100, 0);
    clip_mon = 1'b0;
    chk("clip_x_raddr_range", clip_viol, 0);
    run_img("clip_y", 300, 470, 0);

    // start while busy is ignored (once mid-scan, once mid-emit)
    fill_rand(30);
    run_img("restart_scan", 210, 130, 100);
    run_img("restart_emit", 37, 333, 257);

    // Reset in the middle of emitting block row 2
    fill_rand(40);
    begin
      int k;
      build_model(150, 60);
      done_cnt = 0;
      @(negedge clk);
      xloc = 10'd150; yloc = 9'd60; start = 1'b1; start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!(obuf_we && int'(obuf_addr) == 2*IMG + 1) && k < LAT + 100) begin
        @(negedge clk);
        k++;
      end
      chk("reset_reach_emit", int'(obuf_we && int'(obuf_addr) == 2*IMG + 1), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_obuf_we", int'(obuf_we), 0);
      chk("midrst_obuf_addr", int'(obuf_addr), 0);
      chk("midrst_obuf_data", int'(obuf_data), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_raddr", int'(raddr), 0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      chk("midrst_no_done", done_cnt, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    run_img("after_reset", 150, 60, 0);

    // Randomized regions anywhere on (or off) the screen
    for (int t = 0; t < 4; t++) begin
      fill_rand(int'($urandom_range(80, 5)));
      run_img("random", int'($urandom_range(700)), int'($urandom_range(500)), 0);
    end

    chk("accum_inc_clr_collision", collide, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
